rx_concat: RTL

//  Receive-side width converter between the Ethernet MAC and the NIC core: packs the MAC's
//  8-bit AXI-Stream byte stream into 64-bit AXI-Stream words with tkeep. Byte 0 of a word

---
 rtl/rx_concat_pkg.sv | 24 ++
 rtl/rx_concat_if.sv | 46 ++++
 rtl/rx_concat_word_fifo.sv | 73 +++++++
 rtl/rx_concat.sv | 120 ++++++++++++
 4 files changed

// File: rtl/rx_concat_pkg.sv
// Shared types and constants for the MAC-byte to 64-bit word receive packer.
package rx_concat_pkg;

    localparam int N1             = 64;
    localparam int N2             = 8;
    localparam int BYTES_PER_WORD = N1 / N2;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);
    localparam logic [BYTES_PER_WORD-1:0] ABORT_KEEP = 8'h01;

    typedef enum logic [1:0] {
        SYNC,
        ASSEMBLE,
        DROP,
        ABORT
    } state_t;

    typedef struct packed {
        logic                      tuser;
        logic                      tlast;
        logic [BYTES_PER_WORD-1:0] keep;
        logic [N1-1:0]             data;
    } word_t;

endpackage

// File: rtl/rx_concat_if.sv
// Byte stream from the MAC plus word stream towards the NIC core.
// The slave modport is the packer's view; master is the surrounding logic.
interface rx_concat_if;
    import rx_concat_pkg::*;

    logic [N2-1:0]             rx_axis_mac_tdata;
    logic                      rx_axis_mac_tvalid;
    logic                      rx_axis_mac_tlast;
    logic                      rx_axis_mac_tuser;
    logic [N1-1:0]             rx_axis_tdata;
    logic [BYTES_PER_WORD-1:0] rx_axis_tkeep;
    logic                      rx_axis_tvalid;
    logic                      rx_axis_tlast;
    logic                      rx_axis_tuser;
    logic                      rx_axis_tready;
    logic                      rx_overflow;

    modport slave (
        input  rx_axis_mac_tdata,
        input  rx_axis_mac_tvalid,
        input  rx_axis_mac_tlast,
        input  rx_axis_mac_tuser,
        input  rx_axis_tready,
        output rx_axis_tdata,
        output rx_axis_tkeep,
        output rx_axis_tvalid,
        output rx_axis_tlast,
        output rx_axis_tuser,
        output rx_overflow
    );

    modport master (
        output rx_axis_mac_tdata,
        output rx_axis_mac_tvalid,
        output rx_axis_mac_tlast,
        output rx_axis_mac_tuser,
        output rx_axis_tready,
        input  rx_axis_tdata,
        input  rx_axis_tkeep,
        input  rx_axis_tvalid,
        input  rx_axis_tlast,
        input  rx_axis_tuser,
        input  rx_overflow
    );

endinterface

// File: rtl/rx_concat_word_fifo.sv
// Two-entry word FIFO: head register drives the output directly, tail is the skid slot.
// A push while full is ignored unless the head is popped in the same cycle.
module rx_concat_word_fifo
    import rx_concat_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  push,
    input  word_t push_word,
    input  logic  pop_ready,
    output word_t head_word,
    output logic  head_valid,
    output logic  full
);

    word_t head_reg, head_next;
    word_t tail_reg, tail_next;
    logic  head_valid_reg, head_valid_next;
    logic  tail_valid_reg, tail_valid_next;
    logic  pop;

    assign pop = head_valid_reg & pop_ready;

    always_comb begin
        head_next       = head_reg;
        tail_next       = tail_reg;
        head_valid_next = head_valid_reg;
        tail_valid_next = tail_valid_reg;
        if (pop) begin
            if (tail_valid_reg) begin
                head_next       = tail_reg;
                tail_valid_next = 1'b0;
                if (push) begin
                    tail_next       = push_word;
                    tail_valid_next = 1'b1;
                end
            end else begin
                head_valid_next = 1'b0;
                if (push) begin
                    head_next       = push_word;
                    head_valid_next = 1'b1;
                end
            end
        end else if (push) begin
            if (!head_valid_reg) begin
                head_next       = push_word;
                head_valid_next = 1'b1;
            end else if (!tail_valid_reg) begin
                tail_next       = push_word;
                tail_valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            head_valid_reg <= 1'b0;
            tail_valid_reg <= 1'b0;
        end else begin
            head_reg       <= head_next;
            tail_reg       <= tail_next;
            head_valid_reg <= head_valid_next;
            tail_valid_reg <= tail_valid_next;
        end
    end

    assign head_word  = head_reg;
    assign head_valid = head_valid_reg;
    assign full       = tail_valid_reg;

endmodule

// File: rtl/rx_concat.sv
// Packs the MAC's un-throttleable byte stream into 64-bit words with tkeep.
// Words that cannot be buffered truncate the frame, which is then closed by a bad abort word.
module rx_concat
    import rx_concat_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    rx_concat_if.slave  bus
);

    state_t                    state_reg, state_next;
    logic [N1-1:0]             data_reg, data_next;
    logic [BYTES_PER_WORD-1:0] keep_reg, keep_next;
    logic [IDX_W-1:0]          idx_reg, idx_next;
    logic                      overflow_reg, overflow_next;

    logic [N1-1:0]             lane_data;
    logic [BYTES_PER_WORD-1:0] lane_keep;
    logic                      push;
    word_t                     push_word;
    word_t                     head_word;
    logic                      head_valid;
    logic                      fifo_full;
    logic                      space;

    // A full FIFO still has room when its head leaves in this cycle.
    assign space = !fifo_full || bus.rx_axis_tready;

    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign lane_data[gi*N2 +: N2] = (idx_reg == IDX_W'(gi)) ? bus.rx_axis_mac_tdata
                                                                    : data_reg[gi*N2 +: N2];
            assign lane_keep[gi] = keep_reg[gi] | (idx_reg == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        data_next     = data_reg;
        keep_next     = keep_reg;
        idx_next      = idx_reg;
        overflow_next = 1'b0;
        push          = 1'b0;
        push_word     = '0;
        case (state_reg)
            SYNC: begin
                if (!bus.rx_axis_mac_tvalid) state_next = ASSEMBLE;
            end
            ASSEMBLE: begin
                if (bus.rx_axis_mac_tvalid) begin
                    if (idx_reg == IDX_W'(BYTES_PER_WORD - 1) || bus.rx_axis_mac_tlast) begin
                        push_word = '{tuser: bus.rx_axis_mac_tuser & bus.rx_axis_mac_tlast,
                                      tlast: bus.rx_axis_mac_tlast,
                                      keep:  lane_keep,
                                      data:  lane_data};
                        data_next = '0;
                        keep_next = '0;
                        idx_next  = '0;
                        if (space) begin
                            push = 1'b1;
                        end else begin
                            overflow_next = 1'b1;
                            state_next    = bus.rx_axis_mac_tlast ? ABORT : DROP;
                        end
                    end else begin
                        data_next = lane_data;
                        keep_next = lane_keep;
                        idx_next  = idx_reg + IDX_W'(1);
                    end
                end
            end
            DROP: begin
                if (bus.rx_axis_mac_tvalid && bus.rx_axis_mac_tlast) state_next = ABORT;
            end
            ABORT: begin
                if (space) begin
                    push       = 1'b1;
                    push_word  = '{tuser: 1'b1, tlast: 1'b1, keep: ABORT_KEEP, data: '0};
                    state_next = ASSEMBLE;
                end
            end
            default: state_next = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= SYNC;
            data_reg     <= '0;
            keep_reg     <= '0;
            idx_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            data_reg     <= data_next;
            keep_reg     <= keep_next;
            idx_reg      <= idx_next;
            overflow_reg <= overflow_next;
        end
    end

    rx_concat_word_fifo u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_word  (push_word),
        .pop_ready  (bus.rx_axis_tready),
        .head_word  (head_word),
        .head_valid (head_valid),
        .full       (fifo_full)
    );

    assign bus.rx_axis_tdata  = head_word.data;
    assign bus.rx_axis_tkeep  = head_word.keep;
    assign bus.rx_axis_tlast  = head_word.tlast;
    assign bus.rx_axis_tuser  = head_word.tuser;
    assign bus.rx_axis_tvalid = head_valid;
    assign bus.rx_overflow    = overflow_reg;

endmodule
